// File: rtl/timer_pkg.sv
// Shared types and constants for the timer unit: register map, channel
// state encoding and the divider tap table indexed by control[1:0].
package timer_pkg;

    typedef enum logic [1:0] {
        REG_DIV     = 2'd0,
        REG_COUNT   = 2'd1,
        REG_MODULO  = 2'd2,
        REG_CONTROL = 2'd3
    } reg_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        OVF    = 2'd1,
        RELOAD = 2'd2
    } ch_state_t;

    localparam int TAP_IDX [4] = '{9, 3, 5, 7};

endpackage

// File: rtl/timer_channel.sv
// One programmable counter channel: falling-edge tick detector on a selected
// divider tap, count/modulo/control registers and the delayed-reload FSM.
module timer_channel
    import timer_pkg::*;
#(
    parameter int COUNT_W      = 8,
    parameter int DIV_W        = 16,
    parameter int RELOAD_DELAY = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIV_W-1:0]   div,
    input  logic               wr_count,
    input  logic               wr_modulo,
    input  logic               wr_control,
    input  logic [COUNT_W-1:0] wdata,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] modulo,
    output logic [2:0]         control,
    output logic               irq
);

    // Delay counter holds the remaining OVF cycles minus one.
    localparam int DLY_W = (RELOAD_DELAY > 2) ? $clog2(RELOAD_DELAY - 1) : 1;
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'((RELOAD_DELAY >= 2) ? RELOAD_DELAY - 2 : 0);

    ch_state_t        state;
    logic [DLY_W-1:0] dly;
    logic [3:0]       taps;
    logic             sig;
    logic             prev_sig;
    logic             tick;
    logic             unused_div;

    assign taps = {div[TAP_IDX[3]], div[TAP_IDX[2]], div[TAP_IDX[1]], div[TAP_IDX[0]]};
    assign unused_div = ^div;

    // Gating by enable before edge detection is what makes disable and
    // tap changes able to produce a spurious tick.
    assign sig  = control[2] & taps[control[1:0]];
    assign tick = prev_sig & ~sig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            dly      <= '0;
            count    <= '0;
            modulo   <= '0;
            control  <= '0;
            prev_sig <= 1'b0;
            irq      <= 1'b0;
        end else begin
            prev_sig <= sig;
            irq      <= 1'b0;
            if (wr_modulo) begin
                modulo <= wdata;
            end
            if (wr_control) begin
                control <= wdata[2:0];
            end
            case (state)
                RUN: begin
                    if (wr_count) begin
                        count <= wdata;
                    end else if (tick) begin
                        if (count == '1) begin
                            count <= '0;
                            if (RELOAD_DELAY == 1) begin
                                state <= RELOAD;
                                irq   <= 1'b1;
                            end else begin
                                state <= OVF;
                                dly   <= DLY_LOAD;
                            end
                        end else begin
                            count <= count + COUNT_W'(1);
                        end
                    end
                end
                OVF: begin
                    if (wr_count) begin
                        count <= wdata;
                        state <= RUN;
                    end else if (dly == '0) begin
                        state <= RELOAD;
                        irq   <= 1'b1;
                    end else begin
                        dly <= dly - DLY_W'(1);
                    end
                end
                RELOAD: begin
                    // A same-cycle MODULO write is the value that gets loaded.
                    count <= wr_modulo ? wdata : modulo;
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: rtl/timer_unit.sv
// Timer block on the CPU register bus: one free-running divider shared by
// NUM_CH counter channels, with combinational register readback.
module timer_unit
    import timer_pkg::*;
#(
    parameter int NUM_CH       = 1,
    parameter int COUNT_W      = 8,
    parameter int DIV_W        = 16,
    parameter int RELOAD_DELAY = 4,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [1:0]         reg_sel,
    input  logic [CH_W-1:0]    ch_sel,
    input  logic [COUNT_W-1:0] wdata,
    output logic [COUNT_W-1:0] rdata,
    output logic [NUM_CH-1:0]  irq,
    output logic [7:0]         div_out
);

    reg_sel_t           sel;
    logic [DIV_W-1:0]   div;
    logic [7:0]         div_hi;
    logic [COUNT_W-1:0] count_a  [NUM_CH];
    logic [COUNT_W-1:0] modulo_a [NUM_CH];
    logic [2:0]         control_a[NUM_CH];
    logic [COUNT_W-1:0] cnt_sel;
    logic [COUNT_W-1:0] mod_sel;
    logic [2:0]         ctl_sel;

    assign sel     = reg_sel_t'(reg_sel);
    assign div_hi  = div[DIV_W-1 -: 8];
    assign div_out = div_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (wr_en && sel == REG_DIV) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic wr_ch;
        assign wr_ch = wr_en && (ch_sel == CH_W'(g));

        timer_channel #(
            .COUNT_W     (COUNT_W),
            .DIV_W       (DIV_W),
            .RELOAD_DELAY(RELOAD_DELAY)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .div       (div),
            .wr_count  (wr_ch && sel == REG_COUNT),
            .wr_modulo (wr_ch && sel == REG_MODULO),
            .wr_control(wr_ch && sel == REG_CONTROL),
            .wdata     (wdata),
            .count     (count_a[g]),
            .modulo    (modulo_a[g]),
            .control   (control_a[g]),
            .irq       (irq[g])
        );
    end

    // Channel selects beyond NUM_CH read back as zero count/modulo/control.
    always_comb begin
        cnt_sel = '0;
        mod_sel = '0;
        ctl_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                cnt_sel = count_a[i];
                mod_sel = modulo_a[i];
                ctl_sel = control_a[i];
            end
        end
        case (sel)
            REG_DIV:     rdata = COUNT_W'(div_hi);
            REG_COUNT:   rdata = cnt_sel;
            REG_MODULO:  rdata = mod_sel;
            REG_CONTROL: rdata = {{(COUNT_W-3){1'b1}}, ctl_sel};
            default:     rdata = '0;
        endcase
    end

endmodule

// File: doc/timer_unit.md
Name: timer_unit

Overview:
Parametrised successor to the single hard-wired DIV/TIMA/TMA/TAC logic in the top level. It holds one shared free-running divider and NUM_CH independent programmable counters, each with modulo reload, clock-select and enable. Ticks use falling-edge detection of the selected divider tap. Overflow reload is delayed and can be cancelled, matching the hardware's quirks. The block sits beside memoryunit on the CPU register bus and drives one interrupt-request pulse per channel into the interrupt-status logic.

Parameters:
NUM_CH, 1, number of independent counter channels (1..4)
COUNT_W, 8, width of each counter and modulo register
DIV_W, 16, width of internal divider; DIV register exposes the top 8 bits
RELOAD_DELAY, 4, clk cycles a counter reads 0 after overflow before the modulo load (minimum 1)

Ports:
clk  in  1  CPU clock
rst  in  1  asynchronous active-high reset
wr_en  in  1  register write strobe, one cycle
reg_sel  in  2  register select: 0 DIV, 1 COUNT, 2 MODULO, 3 CONTROL
ch_sel  in  $clog2(NUM_CH) (min 1)  target channel; ignored for DIV
wdata  in  COUNT_W  write data
rdata  out  COUNT_W  combinational read data for reg_sel/ch_sel
irq  out  NUM_CH  one-cycle overflow interrupt request per channel
div_out  out  8  div[DIV_W-1:DIV_W-8], for the sound frame sequencer

Behaviour:
- Reset (async): div=0; every count, modulo and control = 0; irq=0; all channels in RUN; prev_sig=0.
- Divider: div increments by 1 every clk and wraps at 2^DIV_W. Any DIV write clears div to 0 in the same edge. wdata is ignored for DIV writes.
- Tap select per channel, from control[1:0]: 00 bit 9, 01 bit 3, 10 bit 5, 11 bit 7. Enable is control[2]. control[7:3] are not stored.
- sig = control[2] & div[tap]. A tick occurs when prev_sig==1 and sig==0. prev_sig registers sig every clk.
- These quirks are required, not bugs:
  - A DIV write while the tap bit is 1 produces a tick.
  - Clearing the enable bit while the tap bit is 1 produces a tick.
  - Changing the tap select from a 1-bit to a 0-bit produces a tick.
- Channel FSM states: RUN, OVF (counts RELOAD_DELAY-1 down to 0), RELOAD.
  - RUN: on a tick, count <= count+1 (mod 2^COUNT_W). If count was all-ones, count <= 0 and go to OVF, or go directly to RELOAD when RELOAD_DELAY==1.
  - OVF: count stays 0. A COUNT write in this state loads wdata, cancels the reload and the irq, and returns to RUN. Otherwise go to RELOAD when the delay counter reaches 0.
  - RELOAD (one cycle): count <= modulo; irq[ch]=1 this cycle only; return to RUN. A COUNT write in this cycle is ignored. A MODULO write in this cycle is applied and also used for the load, so the new value wins.
- Ticks arriving in OVF or RELOAD are dropped.
- A COUNT write in RUN coinciding with a tick: the write wins and the increment is lost.
- Multiple channels may pulse irq on the same cycle. Each channel is independent.
- rdata by register:
  - DIV: div[DIV_W-1:DIV_W-8], zero-extended or truncated to COUNT_W.
  - COUNT: count.
  - MODULO: modulo.
  - CONTROL: {ones, control[2:0]}.
- Register writes take effect at the next clk edge; a read in the following cycle returns the new value.

Decomposition:
- timer_pkg holds:
  - the reg_sel_t enum (REG_DIV, REG_COUNT, REG_MODULO, REG_CONTROL);
  - the ch_state_t enum (RUN, OVF, RELOAD);
  - TAP_IDX[4] constant array {9,3,5,7}.
- Sub-module timer_channel holds one channel's count/modulo/control, FSM and edge detector. It takes div as an input. timer_unit instantiates NUM_CH of them in a generate loop, owns the divider, and muxes rdata.

Test Plan:
- NUM_CH=1, control=0x05, modulo=0xAB, count=0xFE: 32 clks -> count 0xFF; 16 more clks -> count 0x00 for 4 clks, then 0xAB; irq high exactly 1 cycle coincident with the load.
- Same setup, write count=0x10 on the 2nd OVF cycle -> count 0x10 held, no irq, no reload.
- Write modulo=0x33 in the RELOAD cycle -> count 0x33 and irq fires; a COUNT write of 0x77 in the same cycle is ignored.
- control=0x04 (tap bit 9), wait until div[9]=1, write DIV -> div reads 0 next cycle and count increments by exactly 1.
- control=0x05, clear the enable while div[3]=1 -> one tick; then no further ticks for 1000 clks.
- NUM_CH=2 with ch0 control=0x05 and ch1 control=0x06, both counts at 0xFF and 0xFF aligned -> irq=2'b01 at ch0 overflow; ch1 overflows on its own /64 schedule; reading CONTROL returns 0xFD and 0xFE.
